// File: rtl/beta_pkg.sv
// Shared width definitions for the beta core.
package beta_pkg;
    parameter int unsigned XLEN = 32;
endpackage

// File: rtl/beta_wb_arbiter.sv
// Write-back arbiter: round-robin ALU/LSU onto one register-file write port,
// plus a pending-write scoreboard consulted by issue.
module beta_wb_arbiter
    import beta_pkg::*;
#(
    parameter int unsigned PRIO_INIT = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            alu_valid_i,
    output logic            alu_ready_o,
    input  logic [4:0]      alu_rd_addr_i,
    input  logic [XLEN-1:0] alu_wdata_i,
    input  logic            lsu_valid_i,
    output logic            lsu_ready_o,
    input  logic [4:0]      lsu_rd_addr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    input  logic            rsv_en_i,
    input  logic [4:0]      rsv_addr_i,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    output logic            rs1_busy_o,
    output logic            rs2_busy_o,
    output logic            rf_wr_en_o,
    output logic [4:0]      rf_rd_addr_o,
    output logic [XLEN-1:0] rf_rd_wdata_o
);

    // prio_q: 0 = ALU holds priority, 1 = LSU holds priority
    logic            prio_q, prio_d;
    logic [31:0]     pend_q, pend_d;
    logic            wen_q, wen_d;
    logic [4:0]      addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            alu_gnt, lsu_gnt;

    always_comb begin
        alu_gnt = !rst_i && alu_valid_i && (!lsu_valid_i || !prio_q);
        lsu_gnt = !rst_i && lsu_valid_i && (!alu_valid_i || prio_q);
    end

    always_comb begin
        prio_d = prio_q;
        wen_d  = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        if (alu_gnt) begin
            prio_d = 1'b1;
            addr_d = alu_rd_addr_i;
            data_d = alu_wdata_i;
            wen_d  = |alu_rd_addr_i;
        end else if (lsu_gnt) begin
            prio_d = 1'b0;
            addr_d = lsu_rd_addr_i;
            data_d = lsu_wdata_i;
            wen_d  = |lsu_rd_addr_i;
        end
    end

    // Clear first so a same-cycle reservation of the same register wins.
    always_comb begin
        pend_d = pend_q;
        if (wen_q) begin
            pend_d[addr_q] = 1'b0;
        end
        if (rsv_en_i) begin
            pend_d[rsv_addr_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= (PRIO_INIT != 0);
            pend_q <= '0;
            wen_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            prio_q <= prio_d;
            pend_q <= pend_d;
            wen_q  <= wen_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        alu_ready_o   = alu_gnt;
        lsu_ready_o   = lsu_gnt;
        rs1_busy_o    = pend_q[rs1_addr_i];
        rs2_busy_o    = pend_q[rs2_addr_i];
        rf_wr_en_o    = wen_q;
        rf_rd_addr_o  = addr_q;
        rf_rd_wdata_o = data_q;
    end

endmodule

// File: tb/tb_beta_wb_arbiter.sv
// Bench for beta_wb_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_beta_wb_arbiter;
    import beta_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [4:0]      alu_addr, lsu_addr, rsv_addr, rs1, rs2;
    logic [XLEN-1:0] alu_data, lsu_data;
    logic            rsv_en, busy1, busy2, wen;
    logic [4:0]      rf_addr;
    logic [XLEN-1:0] rf_data;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    bit              m_ok = 0;
    bit              m_prio;            // 0: ALU wins a tie, 1: LSU wins a tie
    bit              m_pend[32];
    bit              m_wen;
    bit [4:0]        m_addr;
    bit [XLEN-1:0]   m_data;
    bit              m_known;           // addr/data only pinned after a real write or reset

    beta_wb_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .alu_valid_i(alu_valid), .alu_ready_o(alu_ready),
        .alu_rd_addr_i(alu_addr), .alu_wdata_i(alu_data),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready),
        .lsu_rd_addr_i(lsu_addr), .lsu_wdata_i(lsu_data),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr),
        .rs1_addr_i(rs1), .rs2_addr_i(rs2),
        .rs1_busy_o(busy1), .rs2_busy_o(busy2),
        .rf_wr_en_o(wen), .rf_rd_addr_o(rf_addr), .rf_rd_wdata_o(rf_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Who the model grants this cycle: 0 none, 1 ALU, 2 LSU
    function automatic int who();
        if (rst) return 0;
        if (alu_valid && lsu_valid) return m_prio ? 2 : 1;
        if (alu_valid) return 1;
        if (lsu_valid) return 2;
        return 0;
    endfunction

    task automatic clr();
        rst = 0; alu_valid = 0; lsu_valid = 0; rsv_en = 0;
        alu_addr = 0; lsu_addr = 0; rsv_addr = 0; rs1 = 0; rs2 = 0;
        alu_data = 0; lsu_data = 0;
    endtask

    task automatic settle();
        int g;
        #2;
        if (m_ok) begin
            g = who();
            chk("alu_ready", alu_ready, (g == 1));
            chk("lsu_ready", lsu_ready, (g == 2));
            chk("rs1_busy", busy1, m_pend[rs1]);
            chk("rs2_busy", busy2, m_pend[rs2]);
            chk("rf_wr_en", wen, m_wen);
            if (m_known) begin
                chk("rf_rd_addr", rf_addr, m_addr);
                chk("rf_rd_wdata", rf_data, m_data);
            end
        end
    endtask

    task automatic adv();
        int g;
        bit [4:0] a;
        g = who();
        @(posedge clk);
        if (rst) begin
            m_ok = 1; m_prio = 0; m_wen = 0; m_addr = 0; m_data = 0; m_known = 1;
            foreach (m_pend[i]) m_pend[i] = 0;
        end else begin
            if (m_wen) m_pend[m_addr] = 0;
            if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1;
            m_wen = 0;
            if (g != 0) begin
                a      = (g == 1) ? alu_addr : lsu_addr;
                m_data = (g == 1) ? alu_data : lsu_data;
                m_addr = a;
                m_wen  = (a != 0);
                m_known = (a != 0);
                m_prio = (g == 1);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        clr(); rst = 1; settle(); adv(); clr();
    endtask

    initial begin
        clr();
        do_reset();

        // ALU-only write
        alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF; settle();
        chk("d034_alu_ready", alu_ready, 1);
        adv(); clr(); settle();
        chk("d034_wen", wen, 1);
        chk("d034_addr", rf_addr, 5);
        chk("d034_data", rf_data, 32'hDEADBEEF);
        adv();

        // Both valid: alternate grants, writes back to back
        do_reset();
        for (int i = 0; i < 5; i++) begin
            clr();
            if (i < 4) begin
                alu_valid = 1; alu_addr = 5'(i + 1); alu_data = 32'hA0 + i;
                lsu_valid = 1; lsu_addr = 5'(i + 11); lsu_data = 32'hB0 + i;
            end
            settle();
            if (i < 4) begin
                chk("d035_alu_ready", alu_ready, (i % 2 == 0));
                chk("d035_lsu_ready", lsu_ready, (i % 2 == 1));
            end
            if (i > 0) begin
                chk("d035_wen", wen, 1);
                chk("d035_addr", rf_addr, (i % 2 == 1) ? 5'(i) : 5'(i + 10));
            end
            adv();
        end

        // LSU write to x0: consumed, no write, priority goes back to ALU
        do_reset();
        alu_valid = 1; alu_addr = 2; settle(); adv(); clr();   // priority now LSU
        lsu_valid = 1; lsu_addr = 0; lsu_data = 32'h1234; settle();
        chk("d036_lsu_ready", lsu_ready, 1);
        adv(); clr();
        alu_valid = 1; alu_addr = 4; lsu_valid = 1; lsu_addr = 6; settle();
        chk("d036_wen", wen, 0);
        chk("d036_alu_prio", alu_ready, 1);
        adv(); clr();

        // Busy across the write cycle
        do_reset();
        rsv_en = 1; rsv_addr = 7; settle(); adv(); clr();
        rs1 = 7; alu_valid = 1; alu_addr = 7; alu_data = 32'h77; settle();
        chk("d037_busy_rsv", busy1, 1);
        adv(); clr(); rs1 = 7; settle();
        chk("d037_wen", wen, 1);
        chk("d037_busy_wr", busy1, 1);
        adv(); clr(); rs1 = 7; settle();
        chk("d037_busy_after", busy1, 0);
        adv();

        // Same-cycle reserve and write of x9: set wins
        do_reset();
        rsv_en = 1; rsv_addr = 9; settle(); adv(); clr();
        alu_valid = 1; alu_addr = 9; settle(); adv(); clr();
        rsv_en = 1; rsv_addr = 9; rs2 = 9; settle();
        chk("d038_wen", wen, 1);
        adv(); clr(); rs2 = 9; settle();
        chk("d038_busy", busy2, 1);
        adv();

        // Reset mid-operation discards the write and reservations
        do_reset();
        rsv_en = 1; rsv_addr = 3; alu_valid = 1; alu_addr = 10; alu_data = 32'h55; settle();
        adv(); clr(); rst = 1; settle();
        chk("d039_rst_alu_ready", alu_ready, 0);
        adv(); clr(); rs1 = 3; rs2 = 10;
        alu_valid = 1; alu_addr = 1; lsu_valid = 1; lsu_addr = 2; settle();
        chk("d039_wen", wen, 0);
        chk("d039_busy1", busy1, 0);
        chk("d039_busy2", busy2, 0);
        chk("d039_prio", alu_ready, 1);
        adv();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            clr();
            rst       = ($urandom_range(0, 99) == 0);
            alu_valid = $urandom_range(0, 1);
            lsu_valid = $urandom_range(0, 1);
            alu_addr  = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            lsu_addr  = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            alu_data  = $urandom;
            lsu_data  = $urandom;
            rsv_en    = $urandom_range(0, 1);
            rsv_addr  = 5'($urandom_range(0, 7));
            rs1       = 5'($urandom_range(0, 7));
            rs2       = 5'($urandom);
            settle();
            tests++;
            if (alu_ready && lsu_ready) begin
                fails++;
                $display("FAIL both_ready: got 1 1 expected at most one at %0t", $time);
            end
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
